// File: rtl/bch_decode_arbiter.sv
// Two-requester round-robin arbiter that serialises N-bit codeword frames into a
// shared decoder slot, with a tag FIFO recording which requester owns each frame.
module bch_decode_arbiter #(
    parameter int N     = 15,
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic in0_valid,
    input  logic in0_data,
    output logic in0_ready,
    input  logic in1_valid,
    input  logic in1_data,
    output logic in1_ready,
    input  logic dec_ce,
    output logic dec_valid,
    output logic dec_data,
    output logic dec_start,
    input  logic out_first,
    output logic out_tag,
    output logic out_tag_valid,
    output logic busy,
    output logic underrun,
    output logic tag_err
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t          state;
    logic            g;
    logic            rr;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [DEPTH-1:0] tag_mem;

    logic full;
    logic empty;
    logic grant;
    logic grant_sel;
    logic g_valid;
    logic g_data;
    logic xfer;
    logic pop;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign grant     = (state == IDLE) && !full && (in0_valid || in1_valid);
    assign grant_sel = (in0_valid && in1_valid) ? rr : in1_valid;
    assign g_valid   = g ? in1_valid : in0_valid;
    assign g_data    = g ? in1_data  : in0_data;
    assign xfer      = (state == STREAM) && dec_ce && g_valid;
    assign pop       = out_first && !empty;

    // Decoder-side outputs are combinational so a bit reaches the decoder in its strobe cycle
    assign in0_ready     = (state == STREAM) && !g && dec_ce;
    assign in1_ready     = (state == STREAM) &&  g && dec_ce;
    assign dec_valid     = xfer;
    assign dec_data      = xfer && g_data;
    assign dec_start     = xfer && (cnt == '0);
    assign out_tag       = !empty && tag_mem[rd_ptr];
    assign out_tag_valid = !empty;
    assign busy          = (state == STREAM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            g        <= 1'b0;
            rr       <= 1'b0;
            cnt      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            underrun <= 1'b0;
            tag_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        state <= STREAM;
                        g     <= grant_sel;
                        cnt   <= '0;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (cnt == LAST_BIT) begin
                            state <= IDLE;
                            cnt   <= '0;
                            rr    <= ~g;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (dec_ce) begin
                        underrun <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Pop acts on the old head; a same-cycle push only lands at the tail
            if (grant) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (out_first && empty) tag_err <= 1'b1;
            case ({grant, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (grant) tag_mem[wr_ptr] <= grant_sel;
    end
endmodule

// File: doc/bch_decode_arbiter.md
BCH_DECODE_ARBITER -- requirements
Module: bch_decode_arbiter

Interface
REQ-001 SHALL have parameter N, default 15: codeword length in bits; each frame transfers exactly N bits.
REQ-002 SHALL have parameter DEPTH, default 4: tag FIFO depth, at least 2, power of two.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports in0_valid/in0_data, input, 1 each: requester 0 serial codeword bit and qualifier.
REQ-006 SHALL have port in0_ready, output, 1: requester 0 bit accepted this cycle when high with in0_valid.
REQ-007 SHALL have ports in1_valid/in1_data (input, 1 each) and in1_ready (output, 1): the same as requester 0, for requester 1.
REQ-008 SHALL have port dec_ce, input, 1: decoder input-slot strobe (interleave enable); at most one bit per strobe.
REQ-009 SHALL have ports dec_valid/dec_data/dec_start, output, 1 each: bit to decoder, its qualifier, and first-bit-of-frame marker.
REQ-010 SHALL have port out_first, input, 1: decoder pulse marking the first decoded bit of an output frame.
REQ-011 SHALL have ports out_tag/out_tag_valid, output, 1 each: requester owning the current output frame, and a flag that the FIFO is non-empty.
REQ-012 SHALL have ports busy, underrun, tag_err, output, 1 each: frame in progress; sticky stall flag; sticky pop-on-empty flag.

Function
REQ-013 SHALL implement states IDLE and STREAM, plus grant register g (1 bit), round-robin pointer rr (1 bit), bit counter cnt ($clog2(N) bits) and tag FIFO (DEPTH x 1).
REQ-014 IDLE: when the FIFO is not full and any inX_valid is high, the block SHALL grant in the same cycle and move to STREAM on the next edge, with cnt=0 and g pushed to the FIFO.
REQ-015 Grant selection: if both requesters are valid, grant rr; if only one is valid, grant that one.
REQ-016 When the FIFO is full, IDLE SHALL hold with no grant and no push.
REQ-017 In IDLE, both inX_ready SHALL be 0 and dec_valid/dec_start SHALL be 0.
REQ-018 STREAM: in{g}_ready SHALL equal dec_ce; the non-granted ready SHALL be 0.
REQ-019 A transfer occurs when dec_ce is high and in{g}_valid is high. On a transfer, dec_valid=1 and dec_data=in{g}_data combinationally, with no register stage.
REQ-020 dec_start SHALL be 1 only on the transfer with cnt==0.
REQ-021 cnt SHALL increment on each transfer and hold otherwise.
REQ-022 The transfer at cnt==N-1 SHALL move the block to IDLE, clear cnt, and set rr to ~g.
REQ-023 A granted requester may not switch mid-frame; the grant is held until N transfers complete, regardless of the other requester.
REQ-024 In STREAM, dec_ce high with in{g}_valid low SHALL set underrun (sticky) and produce no transfer. cnt holds and the frame resumes on the next transfer.
REQ-025 busy SHALL be 1 exactly while in STREAM.
REQ-026 Tag FIFO: a push occurs at each grant. A pop occurs on out_first when the FIFO is non-empty.
REQ-027 out_tag SHALL be the FIFO head and out_tag_valid SHALL be !empty.
REQ-028 Simultaneous push and pop SHALL leave the occupancy unchanged, with the pop applied to the old head.
REQ-029 out_first while the FIFO is empty SHALL be ignored and SHALL set tag_err (sticky), even if a push occurs in the same cycle. The pushed entry becomes visible on the next cycle.
REQ-030 The FIFO full flag SHALL be computed from the registered count. A same-cycle pop does not enable a grant while the FIFO is full.

Reset
REQ-031 When reset is asserted, the block SHALL asynchronously force: state=IDLE, cnt=0, g=0, rr=0, FIFO empty, and underrun=0, tag_err=0.
REQ-032 During reset, all outputs SHALL be 0.
REQ-033 Reset mid-frame SHALL abandon the frame; partial bits are not replayed.
REQ-034 After reset deasserts, the first rising edge SHALL evaluate IDLE normally.

Verification
REQ-035 Scenario: dec_ce=1 constant, in0_valid only, N=15 -> 15 transfers; dec_start on bit 0 only; busy for 15 cycles; out_tag_valid=1 with out_tag=0.
REQ-036 Scenario: both requesters valid continuously -> frames alternate 0,1,0,1; each frame is 15 contiguous bits; the non-granted ready stays 0 throughout.
REQ-037 Scenario: dec_ce high every 3rd cycle -> exactly one transfer per strobe; a frame completes in 45 cycles; no underrun.
REQ-038 Scenario: in0_valid dropped for 2 strobes at cnt=7 -> underrun=1; cnt holds at 7; the frame still totals 15 bits.
REQ-039 Scenario: 4 frames with no out_first -> FIFO full, busy=0 and inX_ready=0 while valid; one out_first -> next grant follows.
REQ-040 Scenario: reset asserted at cnt=9, then out_first with FIFO empty -> all outputs 0 immediately; after release, a new frame restarts at cnt=0 with dec_start; tag_err=1.
